// File: rtl/data_memory_responder_if.sv
// Load/store bus between the LEGv8 CPU and its data memory.
// The CPU is the master; the memory responder is the slave.
interface data_memory_responder_if;
    logic        MEM_REQ;
    logic        MEM_WRITE;
    logic [63:0] MEM_ADDR;
    logic [63:0] MEM_WDATA;
    logic        MEM_READY;
    logic        MEM_RVALID;
    logic [63:0] MEM_RDATA;
    logic        MEM_ERR;
    logic        MEM_BUSY;

    modport master (
        output MEM_REQ, MEM_WRITE, MEM_ADDR, MEM_WDATA,
        input  MEM_READY, MEM_RVALID, MEM_RDATA, MEM_ERR, MEM_BUSY
    );

    modport slave (
        input  MEM_REQ, MEM_WRITE, MEM_ADDR, MEM_WDATA,
        output MEM_READY, MEM_RVALID, MEM_RDATA, MEM_ERR, MEM_BUSY
    );
endinterface

// File: rtl/data_memory_responder.sv
// Multi-cycle LEGv8 data memory with fixed latency and a one-cycle response pulse.
// Optional: define DMEM_ALIGN_CHECK_EN to fault on misaligned (addr[2:0] != 0) accesses.
module data_memory_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic                    CLOCK,
    input  logic                    RESET_N,
    data_memory_responder_if.slave  bus
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [3:0]     r_cnt;
    logic [63:0]    r_addr;
    logic [63:0]    r_wdata;
    logic           r_write;
    logic [63:0]    r_rdata;
    logic           r_err;
    logic [63:0]    r_mem [DEPTH_WORDS];

    logic           w_accept;
    logic           w_enter_resp;
    logic [63:0]    w_rd_addr;
    logic           w_rd_write;
    logic [AW-1:0]  w_rd_idx;
    logic [AW-1:0]  w_st_idx;
    logic           w_oob;
    logic           w_mis;
    logic           w_fault;

    // With zero latency RESP is entered on the accept edge, before the
    // request is latched, so the read/fault path looks at the live bus then.
    assign w_rd_addr  = (r_state == S_IDLE) ? bus.MEM_ADDR : r_addr;
    assign w_rd_write = (r_state == S_IDLE) ? bus.MEM_WRITE : r_write;
    assign w_rd_idx   = w_rd_addr[AW+2:3];
    assign w_st_idx   = r_addr[AW+2:3];
    assign w_oob      = (w_rd_addr[63:3] >= 61'(DEPTH_WORDS));

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_mis = |w_rd_addr[2:0];
`else
    logic w_unused_lsb;
    assign w_mis        = 1'b0;
    assign w_unused_lsb = ^w_rd_addr[2:0];
`endif

    assign w_fault      = w_oob | w_mis;
    assign w_accept     = (r_state == S_IDLE) && bus.MEM_REQ;
    assign w_enter_resp = (r_state != S_RESP) && (w_next == S_RESP);

    assign bus.MEM_READY  = (r_state == S_IDLE);
    assign bus.MEM_BUSY   = (r_state != S_IDLE);
    assign bus.MEM_RVALID = (r_state == S_RESP);
    assign bus.MEM_RDATA  = r_rdata;
    assign bus.MEM_ERR    = r_err;

    // Next-state logic for the IDLE -> WAIT -> RESP -> IDLE sequence.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.MEM_REQ) begin
                    w_next = (LATENCY == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register and wait counter.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cnt <= LAT_M1;
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Request latch and response data/error, cleared once the pulse ends.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_addr  <= 64'd0;
            r_wdata <= 64'd0;
            r_write <= 1'b0;
            r_rdata <= 64'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= bus.MEM_ADDR;
                r_wdata <= bus.MEM_WDATA;
                r_write <= bus.MEM_WRITE;
            end
            if (w_enter_resp) begin
                r_err   <= w_fault;
                r_rdata <= (w_fault || w_rd_write) ? 64'd0 : r_mem[w_rd_idx];
            end else if (r_state == S_RESP) begin
                r_err   <= 1'b0;
                r_rdata <= 64'd0;
            end
        end
    end

    // Store commit on the edge that ends RESP; contents survive reset.
    always_ff @(posedge CLOCK) begin
        if (r_state == S_RESP && r_write && !r_err) begin
            r_mem[w_st_idx] <= r_wdata;
        end
    end
endmodule
